// File: rtl/data_memory_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory_arbiter_if: CPU, debug and data_memory buses of the arbiter.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface data_memory_arbiter_if;
  logic        CPU_Req;
  logic        CPU_W_En;
  logic [2:0]  CPU_Control;
  logic [31:0] CPU_Addr;
  logic [31:0] CPU_W_Data;
  logic        CPU_Stall;
  logic        CPU_R_Valid;
  logic [31:0] CPU_R_Data;
  logic        CPU_Err;

  logic        DBG_Req;
  logic        DBG_W_En;
  logic [2:0]  DBG_Control;
  logic [31:0] DBG_Addr;
  logic [31:0] DBG_W_Data;
  logic        DBG_Ack;
  logic [31:0] DBG_R_Data;
  logic        DBG_Err;

  logic        MEM_W_En;
  logic [2:0]  MEM_Control;
  logic [31:0] RW_Addr;
  logic [31:0] W_Data;
  logic [31:0] Data_Out;

  // slave: the arbiter; master: requesters plus data_memory
  modport slave (
    input  CPU_Req, CPU_W_En, CPU_Control, CPU_Addr, CPU_W_Data,
    output CPU_Stall, CPU_R_Valid, CPU_R_Data, CPU_Err,
    input  DBG_Req, DBG_W_En, DBG_Control, DBG_Addr, DBG_W_Data,
    output DBG_Ack, DBG_R_Data, DBG_Err,
    output MEM_W_En, MEM_Control, RW_Addr, W_Data,
    input  Data_Out
  );

  modport master (
    output CPU_Req, CPU_W_En, CPU_Control, CPU_Addr, CPU_W_Data,
    input  CPU_Stall, CPU_R_Valid, CPU_R_Data, CPU_Err,
    output DBG_Req, DBG_W_En, DBG_Control, DBG_Addr, DBG_W_Data,
    input  DBG_Ack, DBG_R_Data, DBG_Err,
    input  MEM_W_En, MEM_Control, RW_Addr, W_Data,
    output Data_Out
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory_arbiter: shares single-port data_memory between CPU and debug.  |
// | Optional macro DMEM_ARB_FAIR_EN adds a starvation limit for the debug port. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module data_memory_arbiter #(
  parameter int MEM_BYTES    = 256,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  data_memory_arbiter_if.slave   bus
);

  localparam logic [2:0] MEM_BYTE              = 3'd0;
  localparam logic [2:0] MEM_HALFWORD          = 3'd1;
  localparam logic [2:0] MEM_WORD              = 3'd2;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'd3;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'd4;
  localparam logic [31:0] MEM_LIMIT            = 32'(MEM_BYTES);

  if (MEM_BYTES < 4 || STARVE_LIMIT < 1) begin : g_param_check
    $error("data_memory_arbiter: MEM_BYTES must be >= 4 and STARVE_LIMIT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_DBG = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_idle;
  logic w_force_dbg;
  logic w_gnt_cpu;
  logic w_gnt_dbg;
  logic w_cpu_err;
  logic w_dbg_err;

  function automatic logic f_access_err(input logic [2:0] ctrl, input logic [31:0] addr);
    logic misaligned;
    misaligned = ((ctrl == MEM_HALFWORD || ctrl == MEM_HALFWORD_UNSIGNED) && addr[0])
               || (ctrl == MEM_WORD && addr[1:0] != 2'b00);
    return misaligned || (addr >= MEM_LIMIT);
  endfunction

  assign w_idle    = (r_state == IDLE) && !RST;
  assign w_cpu_err = f_access_err(bus.CPU_Control, bus.CPU_Addr);
  assign w_dbg_err = f_access_err(bus.DBG_Control, bus.DBG_Addr);

`ifdef DMEM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve;

  // Saturates at the limit so the forced slot is held until DBG is served
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve <= '0;
    end else if (!bus.DBG_Req || w_gnt_dbg) begin
      r_starve <= '0;
    end else if (w_gnt_cpu && r_starve != STARVE_MAX) begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end

  assign w_force_dbg = bus.DBG_Req && (r_starve == STARVE_MAX);
`else
  assign w_force_dbg = 1'b0;
`endif

  assign w_gnt_cpu = w_idle && bus.CPU_Req && !w_force_dbg;
  assign w_gnt_dbg = w_idle && bus.DBG_Req && (!bus.CPU_Req || w_force_dbg);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.CPU_Stall   = bus.CPU_Req;
    bus.CPU_R_Valid = 1'b0;
    bus.CPU_R_Data  = '0;
    bus.CPU_Err     = 1'b0;
    bus.DBG_Ack     = 1'b0;
    bus.DBG_R_Data  = '0;
    bus.DBG_Err     = 1'b0;
    bus.MEM_W_En    = 1'b0;
    bus.MEM_Control = MEM_WORD;
    bus.RW_Addr     = '0;
    bus.W_Data      = '0;

    if (!RST) begin
      case (r_state)
        IDLE: begin
          if (w_gnt_cpu) begin
            if (w_cpu_err) begin
              bus.CPU_Err     = 1'b1;
              bus.CPU_Stall   = 1'b0;
              bus.CPU_R_Valid = !bus.CPU_W_En;
            end else begin
              bus.MEM_W_En    = bus.CPU_W_En;
              bus.MEM_Control = bus.CPU_Control;
              bus.RW_Addr     = bus.CPU_Addr;
              bus.W_Data      = bus.CPU_W_Data;
              if (bus.CPU_W_En) begin
                bus.CPU_Stall = 1'b0;
              end else begin
                w_next = RD_CPU;
              end
            end
          end else if (w_gnt_dbg) begin
            if (w_dbg_err) begin
              bus.DBG_Ack = 1'b1;
              bus.DBG_Err = 1'b1;
            end else begin
              bus.MEM_W_En    = bus.DBG_W_En;
              bus.MEM_Control = bus.DBG_Control;
              bus.RW_Addr     = bus.DBG_Addr;
              bus.W_Data      = bus.DBG_W_Data;
              if (bus.DBG_W_En) begin
                bus.DBG_Ack = 1'b1;
              end else begin
                w_next = RD_DBG;
              end
            end
          end
        end
        // Read data returns the cycle after the address; no new grant here
        RD_CPU: begin
          bus.CPU_R_Data  = bus.Data_Out;
          bus.CPU_R_Valid = 1'b1;
          bus.CPU_Stall   = 1'b0;
          w_next          = IDLE;
        end
        RD_DBG: begin
          bus.DBG_R_Data = bus.Data_Out;
          bus.DBG_Ack    = 1'b1;
          w_next         = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data_memory between two requesters: the pipeline MEM stage (CPU port) and the debug/loader port (DBG port).
- Sequences the memory's one-cycle synchronous read, returns data to the owning requester, and rejects misaligned or out-of-range accesses before they reach memory.
- Sits between the MEM stage / debug unit and data_memory. Drives the memory's MEM_W_En, MEM_Control, RW_Addr and W_Data, and consumes its Data_Out.

Parameters:
- MEM_BYTES, 256: memory size in bytes; accesses at or above it are errors.
- STARVE_LIMIT, 8: consecutive CPU grants with DBG_Req pending before DBG is forced a slot (fair mode only).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- CPU_Req  in  1  CPU access request; held stable until completion.
- CPU_W_En  in  1  1 = store, 0 = load.
- CPU_Control  in  3  MEM_BYTE / MEM_HALFWORD / MEM_WORD / MEM_BYTE_UNSIGNED / MEM_HALFWORD_UNSIGNED (definitions package).
- CPU_Addr  in  32  byte address.
- CPU_W_Data  in  32  store data.
- CPU_Stall  out  1  access not complete this cycle.
- CPU_R_Valid  out  1  load data valid (1-cycle pulse).
- CPU_R_Data  out  32  load data.
- CPU_Err  out  1  misaligned or out-of-range access (1-cycle pulse).
- DBG_Req, DBG_W_En, DBG_Control, DBG_Addr, DBG_W_Data  in  1/1/3/32/32  same meanings as the CPU port.
- DBG_Ack  out  1  DBG access complete (1-cycle pulse).
- DBG_R_Data  out  32  load data, valid with DBG_Ack on loads.
- DBG_Err  out  1  error, valid with DBG_Ack.
- MEM_W_En  out  1  to data_memory.
- MEM_Control  out  3  to data_memory.
- RW_Addr  out  32  to data_memory.
- W_Data  out  32  to data_memory.
- Data_Out  in  32  from data_memory; valid the cycle after a read address is sampled.

Behaviour:
- FSM states: IDLE, RD_CPU, RD_DBG. On reset the FSM enters IDLE.
- Reset values: the starve counter is 0. All outputs are 0 except CPU_Stall, which equals CPU_Req.
- Memory-side outputs are a combinational mux of the granted port in IDLE. With no grant (or in the RD states): MEM_W_En=0, RW_Addr=0, MEM_Control=MEM_WORD, W_Data=0.
- Arbitration in IDLE: CPU has fixed priority. DBG is granted only when CPU_Req=0.
- Error check at grant:
  - halfword types with Addr[0]=1 are errors;
  - MEM_WORD with Addr[1:0]!=0 is an error;
  - Addr >= MEM_BYTES is an error.
- Erroring access handling:
  - memory is not driven (MEM_W_En=0);
  - the access completes in its grant cycle; the FSM stays in IDLE;
  - CPU: CPU_Err=1, CPU_Stall=0, and for a load also CPU_R_Valid=1 with CPU_R_Data=0;
  - DBG: DBG_Ack=1, DBG_Err=1, DBG_R_Data=0.
- Store, grant cycle: MEM_W_En=1 and the store completes.
  - CPU: CPU_Stall=0.
  - DBG: DBG_Ack=1.
  - FSM stays in IDLE, so back-to-back stores run at 1 per cycle.
- Load, grant cycle: the address is driven and the FSM goes to RD_CPU or RD_DBG.
  - CPU: CPU_Stall=1 in the grant cycle.
- RD_CPU (next cycle): CPU_R_Data=Data_Out, CPU_R_Valid=1, CPU_Stall=0, then go to IDLE.
  - Nothing is granted in this cycle, so load latency is 2 cycles.
- RD_DBG: DBG_R_Data=Data_Out, DBG_Ack=1, then go to IDLE.
  - CPU_Stall equals CPU_Req throughout RD_DBG.
- CPU_Stall=1 whenever CPU_Req=1 and the CPU access does not complete this cycle.
- Simultaneous CPU_Req and DBG_Req: CPU wins. DBG waits with its inputs held.
- If CPU_Req drops while in RD_CPU, the data is still presented; the requester ignores it.
- Reset mid-operation (RD_*): return to IDLE. No R_Valid or Ack is produced and memory contents are untouched.

Optional Feature:
- Macro: DMEM_ARB_FAIR_EN.
- Defined:
  - The starve counter increments on each CPU grant while DBG_Req=1.
  - It clears on a DBG grant, and also whenever DBG_Req=0.
  - When the counter equals STARVE_LIMIT, the next IDLE grant goes to DBG even if CPU_Req=1, and CPU stalls that cycle.
- Undefined: strict CPU priority, no counter logic.

Test Plan:
- CPU store: MEM_WORD, addr 0x4, data 0xFAAFFAAF -> MEM_W_En=1 for 1 cycle, CPU_Stall=0. Then CPU load MEM_WORD 0x4 -> CPU_Stall=1 for 1 cycle, then CPU_R_Valid=1 with CPU_R_Data=0xFAAFFAAF.
- Sign handling: DBG store MEM_HALFWORD 0x2 data 0xF00F, then DBG load MEM_HALFWORD 0x2 -> DBG_R_Data=0xFFFFF00F. Then load MEM_HALFWORD_UNSIGNED 0x2 -> 0x0000F00F. Both returned with DBG_Ack.
- Contention: CPU_Req and DBG_Req both asserted for a 3-store CPU burst -> DBG_Ack only after the CPU burst ends, in the first cycle CPU_Req=0.
- Errors: CPU MEM_WORD at 0x2 -> CPU_Err=1, no MEM_W_En, memory unchanged. DBG load at 0x100 (MEM_BYTES=256) -> DBG_Ack=1, DBG_Err=1, DBG_R_Data=0.
- Reset in RD_CPU: RST=1 for 1 cycle -> no CPU_R_Valid, FSM in IDLE. A reissued load returns the correct data.
- DMEM_ARB_FAIR_EN, STARVE_LIMIT=8: continuous CPU stores plus DBG_Req -> DBG granted on the 9th arbitration, CPU_Stall=1 that cycle.
